seq_vector_sequencer: RTL and testbench
=======================================

Name: seq_vector_sequencer

Overview:
Test-vector controller for the two-flip-flop sequential lab circuit (inputs A/B, outputs Y/Z).
- Stores up to DEPTH input/expected-output vectors and resets the circuit under test.
- For each vector: applies A/B, waits for combinational settle, issues one clock-enable step, waits again, then samples and compares Y/Z.
- Reports mismatch count and first failing index.
- Sits between a host/bench and the circuit; the circuit's flops are clocked by CLK and gated by DUT_STEP.

Parameters:
DEPTH, 8, number of vector slots (power of 2)
AW, 3, log2(DEPTH)
RST_CYCLES, 2, cycles DUT_RST is held high at run start (>=1)
SETTLE, 3, wait cycles after input change and after step (>=1)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
WR_EN  in  1  write WR_DATA into next free slot
WR_DATA  in  4  {A, B, expY, expZ}, MSB first
BUF_CLR  in  1  empty vector buffer
START  in  1  begin run (single-cycle pulse, level tolerated)
DUT_Y  in  1  circuit output Y
DUT_Z  in  1  circuit output Z
DUT_RST  out  1  reset to circuit
DUT_A  out  1  circuit input A
DUT_B  out  1  circuit input B
DUT_STEP  out  1  one-cycle clock-enable to circuit flops
BUSY  out  1  run in progress
DONE  out  1  run finished, sticky
COUNT  out  AW+1  vectors stored (0..DEPTH)
FULL  out  1  COUNT==DEPTH
ERR_CNT  out  AW+1  mismatching vectors in last run
FIRST_ERR  out  AW  index of first mismatch, valid when ERR_CNT!=0

Behaviour:
- All outputs are registered. RST (sync) gives: state IDLE; COUNT=0; DUT_RST=0; DUT_A=0; DUT_B=0; DUT_STEP=0; BUSY=0; DONE=0; ERR_CNT=0; FIRST_ERR=0. Buffer contents are don't-care.
- Buffer:
  - WR_EN in IDLE/FIN with COUNT<DEPTH writes slot[COUNT]; COUNT++ next cycle.
  - WR_EN when FULL or BUSY is ignored.
  - BUF_CLR in IDLE/FIN sets COUNT=0 and has priority over a same-cycle WR_EN. It is ignored when BUSY.
  - START has priority over WR_EN/BUF_CLR in the same cycle; the write/clear is dropped.
- States: IDLE, RSTD, APPLY, WAIT1, STEP, WAIT2, CHECK, FIN.
- IDLE/FIN + START:
  - Clears ERR_CNT, FIRST_ERR and DONE.
  - Sets idx=0 and BUSY=1.
  - If COUNT==0, goes directly to FIN (DONE=1 one cycle after START, BUSY back to 0). Otherwise goes to RSTD.
- RSTD: DUT_RST=1, DUT_A=DUT_B=0 for exactly RST_CYCLES cycles, then APPLY with DUT_RST=0.
- APPLY (1 cycle): DUT_A/DUT_B <= slot[idx] A/B bits.
- WAIT1: SETTLE cycles; A/B held.
- STEP: DUT_STEP=1 for exactly one cycle.
- WAIT2: SETTLE cycles.
- CHECK (1 cycle): compare registered DUT_Y/DUT_Z with expY/expZ.
  - On mismatch: ERR_CNT++ (saturating at DEPTH); if this is the first mismatch, FIRST_ERR=idx.
  - If idx==COUNT-1, go to FIN; else idx++ and go to APPLY.
- Per-vector latency: 2*SETTLE+3 cycles. Full run: RST_CYCLES + COUNT*(2*SETTLE+3) cycles from START to DONE rising.
- FIN: BUSY=0, DONE=1. DUT_A/DUT_B hold the last vector. Stays in FIN until START, BUF_CLR or RST.
- START while BUSY is ignored.
- DUT_A/DUT_B never change in WAIT1, STEP, WAIT2 or CHECK.
- DUT_STEP is never high outside STEP.
- RST mid-run: returns to IDLE the next cycle with reset values. DUT_STEP drops immediately. The buffer is lost (COUNT=0).
- Buffer contents are retained across runs; START again replays the same vectors.

Test Plan:
- Reset/idle: assert RST 2 cycles -> all outputs 0, COUNT=0, FULL=0; START with empty buffer -> BUSY=1 for 1 cycle, DONE=1 on cycle 2, ERR_CNT=0.
- Fill/overflow: write 9 vectors at DEPTH=8 -> COUNT=8, FULL=1, 9th ignored; BUF_CLR together with WR_EN -> COUNT=0.
- Pass run: 3 vectors {1,0,1,0},{0,1,0,1},{0,0,0,0}, bench DUT echoes the expected bits -> DUT_RST high cycles 1-2 after START, exactly 3 DUT_STEP pulses spaced 9 cycles apart, DONE at cycle 2+3*9=29, ERR_CNT=0.
- Fail run: same vectors, bench forces DUT_Z=1 always -> ERR_CNT=2 (vectors 0 and 2), FIRST_ERR=0; rerun via START clears and reproduces ERR_CNT=2.
- Protocol abuse: START and WR_EN pulsed during a run -> no restart, COUNT unchanged, A/B stable through each WAIT1/STEP/WAIT2/CHECK window.
- Mid-run reset: RST during the WAIT2 of vector 1 -> next cycle IDLE, BUSY=0, DUT_STEP=0, COUNT=0, DONE=0.

Source files
------------

// File: rtl/seq_vector_sequencer.sv
// Test-vector sequencer for the two-flop lab circuit: stores A/B stimulus with
// expected Y/Z, resets the circuit, steps it once per vector and tallies mismatches.
//
// state | meaning
// IDLE  | waiting; buffer writable
// RSTD  | holding circuit reset for RST_CYCLES
// APPLY | driving A/B of the current vector
// WAIT1 | settle after input change
// STEP  | one-cycle clock enable to circuit flops
// WAIT2 | settle after step
// CHECK | compare sampled Y/Z against expectation
// FIN   | run complete; results held, buffer writable
module seq_vector_sequencer #(
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int RST_CYCLES = 2,
  parameter int SETTLE     = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WR_EN,
  input  logic [3:0]    WR_DATA,
  input  logic          BUF_CLR,
  input  logic          START,
  input  logic          DUT_Y,
  input  logic          DUT_Z,
  output logic          DUT_RST,
  output logic          DUT_A,
  output logic          DUT_B,
  output logic          DUT_STEP,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW:0]   COUNT,
  output logic          FULL,
  output logic [AW:0]   ERR_CNT,
  output logic [AW-1:0] FIRST_ERR
);

  localparam int TMAX = (RST_CYCLES > SETTLE) ? RST_CYCLES : SETTLE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] RST_LOAD = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] SET_LOAD = TW'(SETTLE - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_RSTD, S_APPLY, S_WAIT1, S_STEP, S_WAIT2, S_CHECK, S_FIN
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      mem [DEPTH];
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d, idx_inc, ferr_q, ferr_d;
  logic [AW:0]     count_q, count_d, err_q, err_d;
  logic            rst_q, rst_d, a_q, a_d, b_q, b_d, step_q, step_d;
  logic            busy_q, busy_d, done_q, done_d, full_q;
  logic            y_q, z_q, wr_go, mismatch, last_vec;
  logic [3:0]      cur_vec, nxt_vec, first_vec;

  assign idx_inc   = idx_q + AW'(1);
  assign cur_vec   = mem[idx_q];
  assign nxt_vec   = mem[idx_inc];
  assign first_vec = mem[0];
  assign mismatch  = {y_q, z_q} != cur_vec[1:0];
  assign last_vec  = {1'b0, idx_q} == count_q - (AW+1)'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    count_d = count_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    rst_d   = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    step_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    wr_go   = 1'b0;
    case (state_q)
      S_IDLE, S_FIN: begin
        // FIN entered straight from START on an empty buffer still shows BUSY for a cycle
        if (state_q == S_FIN) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
        if (!busy_q) begin
          if (START) begin
            err_d  = '0;
            ferr_d = '0;
            done_d = 1'b0;
            idx_d  = '0;
            busy_d = 1'b1;
            if (count_q == '0) begin
              state_d = S_FIN;
            end else begin
              state_d = S_RSTD;
              cnt_d   = RST_LOAD;
              rst_d   = 1'b1;
              a_d     = 1'b0;
              b_d     = 1'b0;
            end
          end else if (BUF_CLR) begin
            count_d = '0;
            state_d = S_IDLE;
          end else if (WR_EN && count_q != FULL_CNT) begin
            wr_go   = 1'b1;
            count_d = count_q + (AW+1)'(1);
          end
        end
      end
      S_RSTD: begin
        if (cnt_q == '0) begin
          state_d = S_APPLY;
          a_d     = first_vec[3];
          b_d     = first_vec[2];
        end else begin
          cnt_d = cnt_q - TW'(1);
          rst_d = 1'b1;
        end
      end
      S_APPLY: begin
        state_d = S_WAIT1;
        cnt_d   = SET_LOAD;
      end
      S_WAIT1: begin
        if (cnt_q == '0) begin
          state_d = S_STEP;
          step_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      S_STEP: begin
        state_d = S_WAIT2;
        cnt_d   = SET_LOAD;
      end
      S_WAIT2: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - TW'(1);
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q == '0)      ferr_d = idx_q;
          if (err_q != FULL_CNT) err_d = err_q + (AW+1)'(1);
        end
        if (last_vec) begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_inc;
          state_d = S_APPLY;
          a_d     = nxt_vec[3];
          b_d     = nxt_vec[2];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      rst_q   <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      y_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      rst_q   <= rst_d;
      a_q     <= a_d;
      b_q     <= b_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      full_q  <= count_d == FULL_CNT;
      y_q     <= DUT_Y;
      z_q     <= DUT_Z;
    end
  end

  // Vector storage has no reset so it can map onto plain RAM
  always_ff @(posedge CLK) begin
    if (wr_go) mem[count_q[AW-1:0]] <= WR_DATA;
  end

  assign DUT_RST   = rst_q;
  assign DUT_A     = a_q;
  assign DUT_B     = b_q;
  assign DUT_STEP  = step_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign COUNT     = count_q;
  assign FULL      = full_q;
  assign ERR_CNT   = err_q;
  assign FIRST_ERR = ferr_q;

endmodule

// File: tb/tb_seq_vector_sequencer.sv
// Bench for seq_vector_sequencer: a lab-circuit stand-in (Y<=A, Z<=B on step, Z optionally
// stuck high) and a timeline model of the run, compared against the DUT every cycle.
module tb_seq_vector_sequencer;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int R = 2;
  localparam int S = 3;
  localparam int P = 2*S + 3;

  logic CLK = 1'b0;
  logic RST, WR_EN, BUF_CLR, START, DUT_Y, DUT_Z;
  logic [3:0] WR_DATA;
  logic DUT_RST, DUT_A, DUT_B, DUT_STEP, BUSY, DONE, FULL;
  logic [AW:0] COUNT, ERR_CNT;
  logic [AW-1:0] FIRST_ERR;

  seq_vector_sequencer #(.DEPTH(DEPTH), .AW(AW), .RST_CYCLES(R), .SETTLE(S)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .BUF_CLR(BUF_CLR),
    .START(START), .DUT_Y(DUT_Y), .DUT_Z(DUT_Z), .DUT_RST(DUT_RST), .DUT_A(DUT_A),
    .DUT_B(DUT_B), .DUT_STEP(DUT_STEP), .BUSY(BUSY), .DONE(DONE), .COUNT(COUNT),
    .FULL(FULL), .ERR_CNT(ERR_CNT), .FIRST_ERR(FIRST_ERR));

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_e = 0;
  bit chk_en = 0;
  bit force_z = 0;
  int step_at[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // lab circuit stand-in
  logic cy = 1'b0, cz = 1'b0;
  always @(posedge CLK) begin
    if (DUT_RST) begin cy <= 1'b0; cz <= 1'b0; end
    else if (DUT_STEP) begin cy <= DUT_A; cz <= DUT_B; end
  end
  assign DUT_Y = cy;
  assign DUT_Z = cz | force_z;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Model: run position m_c counts cycles since the START edge (1 = first cycle after it)
  int m_count, m_err, m_ferr, m_c, m_k, m_v;
  logic [3:0] m_slot [DEPTH];
  bit m_busy, m_done, m_rst, m_a, m_b, m_step, m_run, m_pend, m_fin;

  always @(posedge CLK) begin
    if (RST) begin
      m_count = 0; m_err = 0; m_ferr = 0; m_busy = 0; m_done = 0;
      m_rst = 0; m_a = 0; m_b = 0; m_step = 0; m_run = 0; m_pend = 0;
    end else if (m_pend) begin
      m_pend = 0; m_busy = 0; m_done = 1;
    end else if (m_run) begin
      m_fin = 0;
      m_k = m_c - R - 1;
      if (m_c > R && (m_k % P) == P-1) begin
        m_v = m_k / P;
        if ({m_slot[m_v][3], m_slot[m_v][2] | force_z} != m_slot[m_v][1:0]) begin
          if (m_err == 0) m_ferr = m_v;
          if (m_err < DEPTH) m_err++;
        end
        if (m_v == m_count - 1) begin
          m_run = 0; m_busy = 0; m_done = 1; m_fin = 1;
        end
      end
      if (!m_fin) begin
        m_c++;
        if (m_c <= R) begin
          m_rst = 1; m_a = 0; m_b = 0; m_step = 0;
        end else begin
          m_k = m_c - R - 1;
          m_v = m_k / P;
          m_rst = 0;
          m_a = m_slot[m_v][3];
          m_b = m_slot[m_v][2];
          m_step = ((m_k % P) == S + 1);
        end
      end
    end else if (START) begin
      m_err = 0; m_ferr = 0; m_done = 0; m_busy = 1;
      if (m_count == 0) m_pend = 1;
      else begin m_run = 1; m_c = 1; m_rst = 1; m_a = 0; m_b = 0; end
    end else if (BUF_CLR) begin
      m_count = 0;
    end else if (WR_EN && m_count < DEPTH) begin
      m_slot[m_count] = WR_DATA;
      m_count++;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("dut_rst", DUT_RST, m_rst);
      chk("dut_a", DUT_A, m_a);
      chk("dut_b", DUT_B, m_b);
      chk("dut_step", DUT_STEP, m_step);
      chk("busy", BUSY, m_busy);
      chk("done", DONE, m_done);
      chk("count", COUNT, m_count);
      chk("full", FULL, m_count == DEPTH);
      chk("err_cnt", ERR_CNT, m_err);
      chk("first_err", FIRST_ERR, m_ferr);
      if (DUT_STEP === 1'b1) step_at.push_back(cyc);
    end
  end

  task automatic write_vec(input logic [3:0] d);
    WR_EN = 1; WR_DATA = d;
    @(negedge CLK);
    WR_EN = 0;
  endtask

  task automatic start_run();
    START = 1;
    @(negedge CLK);
    START = 0;
    start_e = cyc;
    step_at.delete();
  endtask

  task automatic wait_done(output int lat);
    int n = 0;
    while (DONE !== 1'b1 && n < 200) begin @(negedge CLK); n++; end
    if (n >= 200) chk("done_timeout", DONE, 1);
    lat = cyc - start_e;
  endtask

  task automatic clear_buf();
    BUF_CLR = 1;
    @(negedge CLK);
    BUF_CLR = 0;
  endtask

  int lat, n;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1; WR_EN = 0; BUF_CLR = 0; START = 0; WR_DATA = 4'h0;
    @(negedge CLK);
    chk_en = 1;
    @(negedge CLK);
    chk("reset_count", COUNT, 0);
    chk("reset_full", FULL, 0);
    chk("reset_busy", BUSY, 0);
    RST = 0;
    @(negedge CLK);

    // empty buffer run
    start_run();
    chk("empty_busy", BUSY, 1);
    wait_done(lat);
    chk("empty_latency", lat, 1);
    chk("empty_busy_after", BUSY, 0);
    chk("empty_err", ERR_CNT, 0);

    // fill and overflow
    for (int i = 0; i < 9; i++) write_vec(4'(i));
    chk("fill_count", COUNT, 8);
    chk("fill_full", FULL, 1);
    WR_EN = 1; BUF_CLR = 1;
    @(negedge CLK);
    WR_EN = 0; BUF_CLR = 0;
    chk("clr_count", COUNT, 0);

    // passing run
    write_vec(4'b1010); write_vec(4'b0101); write_vec(4'b0000);
    force_z = 0;
    start_run();
    chk("pass_rst_first", DUT_RST, 1);
    wait_done(lat);
    chk("pass_latency", lat, 29);
    chk("pass_err", ERR_CNT, 0);
    chk("pass_steps", step_at.size(), 3);
    if (step_at.size() == 3) begin
      chk("step0_offset", step_at[0] - start_e, 6);
      chk("step_gap1", step_at[1] - step_at[0], 9);
      chk("step_gap2", step_at[2] - step_at[1], 9);
    end

    // failing run, Z stuck high, then replay
    force_z = 1;
    start_run();
    wait_done(lat);
    chk("fail_err", ERR_CNT, 2);
    chk("fail_first", FIRST_ERR, 0);
    start_run();
    chk("rerun_cleared", ERR_CNT, 0);
    wait_done(lat);
    chk("rerun_err", ERR_CNT, 2);
    chk("rerun_latency", lat, 29);

    // protocol abuse during a run
    force_z = 0;
    start_run();
    for (int i = 0; i < 20; i++) begin
      START = (i % 3 == 0);
      WR_EN = (i % 4 == 1);
      WR_DATA = 4'($urandom_range(0, 15));
      @(negedge CLK);
    end
    START = 0; WR_EN = 0;
    wait_done(lat);
    chk("abuse_latency", lat, 29);
    chk("abuse_count", COUNT, 3);

    // reset during WAIT2 of vector 1
    start_run();
    repeat (17) @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    RST = 0;
    chk("midrst_busy", BUSY, 0);
    chk("midrst_step", DUT_STEP, 0);
    chk("midrst_count", COUNT, 0);
    chk("midrst_done", DONE, 0);
    @(negedge CLK);

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      clear_buf();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) write_vec(4'($urandom_range(0, 15)));
      force_z = bit'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      start_run();
      wait_done(lat);
      chk("rand_latency", lat, R + n*P);
    end

    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
